// File: rtl/aes_disp_pkg.sv
// aes_disp_pkg: shared widths, pager state encoding and the block word selector.
package aes_disp_pkg;
    localparam int BLOCK_W   = 128;
    localparam int WORD_W    = 16;
    localparam int NUM_WORDS = 8;
    localparam int IDX_W     = 3;

    typedef enum logic [1:0] {EMPTY, MANUAL, AUTO} state_t;

    // Word 0 occupies the most significant 16 bits, so index 0 maps to bit offset 112.
    function automatic logic [WORD_W-1:0] word_at(input logic [BLOCK_W-1:0] blk,
                                                  input logic [IDX_W-1:0] idx);
        return blk[{~idx, 4'b0000} +: WORD_W];
    endfunction
endpackage

// File: rtl/aes_display_pager_btn_sync_edge.sv
// btn_sync_edge: multi-flop synchroniser for an asynchronous button plus rising-edge pulse.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic i_btn,
    output logic o_rise
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_sync <= '0;
            r_last <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_last <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_last;
endmodule

// File: rtl/aes_display_pager.sv
// aes_display_pager: holds a 128-bit AES block and pages it to a 7-segment driver one
// 16-bit word at a time, on buttons or a timer, pulsing refresh on every change.
module aes_display_pager
    import aes_disp_pkg::*;
#(
    parameter int AUTO_TICKS  = 100_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [0:127]  i_block,
    input  logic          i_block_valid,
    input  logic          i_next,
    input  logic          i_prev,
    input  logic          i_auto_mode,
    output logic [0:15]   o_data,
    output logic          o_refresh_display,
    output logic [2:0]    o_word_idx,
    output logic          o_have_block
);
    localparam int TW = $clog2(AUTO_TICKS);

    state_t             r_state;
    logic [BLOCK_W-1:0] r_block;
    logic [WORD_W-1:0]  r_data;
    logic [IDX_W-1:0]   r_idx;
    logic [TW-1:0]      r_timer;
    logic               r_refresh;
    logic               r_have;
    logic               w_rise_n, w_rise_p, w_tick, w_fwd, w_back;
    logic [IDX_W-1:0]   w_new_idx;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_next (.clk(clk), .clr(clr), .i_btn(i_next), .o_rise(w_rise_n));
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_prev (.clk(clk), .clr(clr), .i_btn(i_prev), .o_rise(w_rise_p));

    // Simultaneous next/prev cancel each other and still suppress the timer move.
    assign w_tick    = (r_state == AUTO) && (r_timer == TW'(AUTO_TICKS - 1));
    assign w_fwd     = (w_rise_n & ~w_rise_p) | (~w_rise_n & ~w_rise_p & w_tick);
    assign w_back    = w_rise_p & ~w_rise_n;
    assign w_new_idx = w_back ? r_idx - 3'd1 : r_idx + 3'd1;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= EMPTY;
            r_block   <= '0;
            r_data    <= '0;
            r_idx     <= '0;
            r_timer   <= '0;
            r_refresh <= 1'b0;
            r_have    <= 1'b0;
        end else if (i_block_valid) begin
            r_state   <= i_auto_mode ? AUTO : MANUAL;
            r_block   <= i_block;
            r_data    <= word_at(i_block, '0);
            r_idx     <= '0;
            r_timer   <= '0;
            r_refresh <= 1'b1;
            r_have    <= 1'b1;
        end else begin
            r_refresh <= 1'b0;
            if (r_state != EMPTY) begin
                r_state <= i_auto_mode ? AUTO : MANUAL;
                if (w_fwd | w_back) begin
                    r_idx     <= w_new_idx;
                    r_data    <= word_at(r_block, w_new_idx);
                    r_refresh <= 1'b1;
                end
            end
            r_timer <= (r_state != AUTO || w_rise_n || w_rise_p || w_tick) ? '0 : r_timer + TW'(1);
        end
    end

    assign o_data            = r_data;
    assign o_refresh_display = r_refresh;
    assign o_word_idx        = r_idx;
    assign o_have_block      = r_have;
endmodule

// File: doc/aes_display_pager.md
Name: aes_display_pager

Overview:
- Sits directly upstream of the 7-segment display driver; feeds its 16-bit data and refresh-pulse inputs.
- Captures a 128-bit AES result block and presents it one 16-bit word at a time (8 pages).
- Pages advance or retreat on board push-buttons, or automatically on a timer.
- Each page change issues a single-cycle refresh pulse so the driver latches the new word.

Parameters:
- AUTO_TICKS, 100_000_000, clock cycles between automatic page advances (1 s at 100 MHz); must be >= 2.
- SYNC_STAGES, 2, flip-flop stages in each button synchroniser; must be >= 2.

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous active-high reset
- i_block  in  128 [0:127]  AES result; word i = i_block[16*i : 16*i+15], so word 0 is the MSBs
- i_block_valid  in  1  single-cycle strobe; i_block is valid in the same cycle
- i_next  in  1  asynchronous push-button, advance page
- i_prev  in  1  asynchronous push-button, retreat page
- i_auto_mode  in  1  level (switch), 1 = timed auto-advance
- o_data  out  16 [0:15]  current word; connects to the display's i_data
- o_refresh_display  out  1  one-cycle pulse on every o_data update; connects to the display's i_refresh_display
- o_word_idx  out  3  current page index, for LEDs
- o_have_block  out  1  a block has been captured since reset

Behaviour:
- Reset is synchronous: on a clk edge with clr=1, o_data=16'h0000, o_refresh_display=0, o_word_idx=0, o_have_block=0, state=EMPTY, timer=0, block register=0, synchroniser flops=0.
- States:
  - EMPTY: the only state leaving reset.
  - MANUAL: a block is held; pages change on buttons only.
  - AUTO: a block is held; pages change on buttons and on the timer.
- Transitions:
  - EMPTY -> MANUAL or AUTO on i_block_valid, selected by i_auto_mode.
  - MANUAL <-> AUTO follows i_auto_mode every cycle while a block is held.
  - No path back to EMPTY except clr.
- Buttons:
  - Each button passes through SYNC_STAGES flops, then rising-edge detection produces a one-cycle event.
  - i_next sampled high at edge k -> with SYNC_STAGES=2, o_data/o_word_idx update and o_refresh_display=1 after edge k+2.
  - Holding a button produces exactly one event; re-arming requires a 0 sample.
- Block capture:
  - On the edge where i_block_valid=1: latch i_block, set o_word_idx=0, o_data=i_block[0:15], o_refresh_display=1 (latency 1 edge), o_have_block=1, timer=0.
  - Capture is honoured in every state.
- Navigation:
  - next: idx+1 mod 8 (7 -> 0).
  - prev: idx-1 mod 8 (0 -> 7).
  - Every move sets o_data=word[new idx] and pulses o_refresh_display for exactly one cycle.
- Auto timer:
  - Counts only in AUTO.
  - When it reaches AUTO_TICKS-1 it wraps to 0 and performs a next move.
  - The timer is cleared on any button event, on block capture, and on any cycle outside AUTO.
- Priority within one cycle: block_valid > button events > timer.
  - next and prev events in the same cycle cancel: no move, no pulse.
  - A button event suppresses a timer move in the same cycle.
  - At most one move and one pulse per cycle.
- EMPTY: button and timer events are ignored; o_refresh_display stays 0.
- o_refresh_display is 0 in every cycle without a move or capture, so the downstream display holds its last word.
- clr mid-operation: everything returns to reset values at that edge. Button edges pending in the synchronisers are discarded.
- Width rules:
  - Timer width is $clog2(AUTO_TICKS).
  - o_word_idx is 3 bits, and wrap is native modulo-8 arithmetic.

Decomposition:
- Package aes_disp_pkg:
  - constants BLOCK_W=128, WORD_W=16, NUM_WORDS=8, IDX_W=3
  - state enum {EMPTY, MANUAL, AUTO}
- Sub-module btn_sync_edge (parameter SYNC_STAGES; ports clk, clr, i_btn, o_rise), instantiated once per button.
- Word select is a mux on the block register. Timer and FSM live in the top module.

Test Plan (blocks written with word 0 first):
- Capture: clr 2 cycles; i_block=128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF with i_block_valid for 1 cycle; MANUAL.
  -> next edge: o_data=16'h0011, o_word_idx=0, o_refresh_display=1 for exactly 1 cycle, o_have_block=1.
- Wrap: same block, press i_prev once (held 10 cycles).
  -> exactly one pulse, 2 edges after first sample; idx=7, o_data=16'hEEFF.
  -> then press i_next once -> idx=0, o_data=16'h0011.
- Auto (AUTO_TICKS=5, i_auto_mode=1): after capture, no buttons.
  -> pulses every 5 cycles; idx sequence 1,2,...,7,0; o_data=16'h2233 at idx 1.
  -> press i_next at idx 3: idx=4, timer restarts, next auto move 5 cycles after that press.
- Simultaneous events:
  - i_next and i_prev rise on the same edge -> no pulse, idx unchanged.
  - New i_block_valid (block 128'hFFFF_0000_...) coincident with a button event -> idx=0, o_data=16'hFFFF, one pulse.
- EMPTY, then reset: buttons pressed before any capture -> o_refresh_display never asserts, o_data=0.
  - Assert clr mid-auto-run at idx 5 -> next edge all outputs reset, state EMPTY, no further pulses.
